ifu_fetch_ibuf: RTL and testbench
=================================

Name: ifu_fetch_ibuf

Overview:
Instruction fetch and buffer stage directly downstream of the RF-stage PC generator. Each cycle it takes the current pc and issues one instruction-memory request, with at most one request outstanding. Returned instructions are stored with their pc in a small FIFO that feeds decode. The block drives the stall signal that holds the PC generator, and squashes in-flight and buffered work on a ROB redirect.

Parameters:
DEPTH, 4, instruction buffer entries (power of 2, ≥2)
PC_W, 64, pc / address width
INST_W, 32, instruction width

Ports:
clk  in  1  clock
rst_clk  in  1  asynchronous, active-low reset
pc  in  PC_W  current fetch pc from PC generator
rob_ifu_flush  in  1  ROB redirect; same signal that loads PC generator from its jump station
ifu_stall  out  1  to PC generator y_stall_ctrl; low only in the cycle pc is consumed
imem_req_vld  out  1  fetch request valid
imem_req_rdy  in  1  memory accepts request
imem_req_addr  out  PC_W  fetch address (= pc)
imem_rsp_vld  in  1  response valid, at earliest one cycle after handshake
imem_rsp_data  in  INST_W  fetched instruction
ifu_idu_inst_vld  out  1  buffer head valid
ifu_idu_inst  out  INST_W  head instruction
ifu_idu_pc  out  PC_W  head pc
idu_ifu_inst_rdy  in  1  decode pops head when vld && rdy

Behaviour:
- States: IDLE, REQ, WAIT, DROP. Reset state is IDLE. At reset: FIFO empty, ifu_idu_inst_vld=0, ifu_idu_inst=0, ifu_idu_pc=0, imem_req_vld=0, ifu_stall=1.
- Credit: credit_ok = (count + (state==WAIT)) < DEPTH. A push never overflows.
- IDLE: imem_req_vld=0. Go to REQ when credit_ok.
- REQ: imem_req_vld=1, imem_req_addr=pc.
  - On handshake (vld && rdy): latch pc into pc_q, ifu_stall=0 for that cycle only (PC generator advances to pc+4), go to WAIT.
  - If no handshake: stay in REQ. The request stays asserted and pc is stable because stall=1.
- WAIT: imem_req_vld=0, ifu_stall=1. On imem_rsp_vld, push {pc_q, imem_rsp_data}, then go to REQ if credit_ok after the push/pop, otherwise IDLE.
- DROP: imem_req_vld=0, ifu_stall=1. On imem_rsp_vld, discard the data and go to IDLE.
- ifu_stall=1 in every cycle except a REQ handshake cycle.
- Stray imem_rsp_vld in IDLE or REQ is ignored.
- FIFO:
  - Head is combinational from storage.
  - Push and pop in the same cycle are allowed at any occupancy, including full with a pop.
  - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- Flush (rob_ifu_flush=1) has priority over all other events in that cycle:
  - FIFO emptied at the edge; pop and push that cycle are discarded; ifu_idu_inst_vld=0 from the next cycle.
  - REQ without handshake → IDLE.
  - REQ with handshake that same cycle → DROP (response is for the stale pc).
  - WAIT without rsp → DROP.
  - WAIT with rsp → IDLE, data discarded.
  - DROP stays in DROP until its response arrives.
  - ifu_stall is don't-care in the flush cycle; the PC generator gives redirect priority.
- Throughput: with a 1-cycle memory, one instruction per 2 cycles. Latency from handshake cycle N with rsp at N+1: head valid at N+2.
- Reset asserted mid-operation: all state returns to reset values immediately. An outstanding response arriving after reset release lands in IDLE and is ignored.

Decomposition:
- Package ifu_pkg holds:
  - state enum (IDLE, REQ, WAIT, DROP)
  - PC_W, INST_W, DEPTH defaults
  - PC_RESET constant shared with the PC generator
  - entry struct {pc, inst}
- Sub-module ifu_ibuf_fifo: parameterised sync FIFO with push, pop, flush, count, full, empty.
- The FSM and credit logic stay in the top module.

Test Plan:
- Reset release, pc=0x80000000, rdy=1, rsp 1 cycle later with 0x00000013 → handshake in cycle 1 with stall=0; inst_vld=1, inst=0x13, pc=0x80000000 two cycles later.
- imem_req_rdy held 0 for 3 cycles → req_vld=1, addr constant at 0x80000004, stall=1 throughout; stall=0 only in the rdy cycle.
- idu_ifu_inst_rdy=0 with DEPTH=4 → exactly 4 entries fetched, pcs 0x80000000..0x8000000C; no fifth request until one pop, then REQ resumes.
- Flush in the same cycle as a handshake at 0x80000008 → DROP; the next rsp is discarded; FIFO empty; the next request uses the new pc (e.g. 0x80001000).
- Flush in WAIT with rsp in the same cycle, FIFO holding 2 entries plus a pop → inst_vld=0 next cycle, state IDLE, count=0.
- Stray imem_rsp_vld=1 in IDLE after reset → no push; inst_vld stays 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch / buffer stage.
//   DEF_PC_W, DEF_INST_W, DEF_DEPTH : default widths and buffer depth
//   PC_RESET                        : boot pc, shared with the PC generator
//   ifu_state_e                     : fetch FSM states
//   ifu_entry_t                     : one buffered fetch {pc, inst}
package ifu_pkg;

  localparam int DEF_PC_W   = 64;
  localparam int DEF_INST_W = 32;
  localparam int DEF_DEPTH  = 4;

  localparam logic [DEF_PC_W-1:0] PC_RESET = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_ibuf_if.sv
// Bus bundle of the fetch stage: instruction-memory request/response and
// the instruction stream handed to decode.
//   master : fetch stage side (drives requests and the decode stream)
//   slave  : memory + decode side
interface ifu_fetch_ibuf_if import ifu_pkg::*; #(
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W
) ();

  logic              imem_req_vld;
  logic              imem_req_rdy;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_rsp_vld;
  logic [INST_W-1:0] imem_rsp_data;
  logic              ifu_idu_inst_vld;
  logic [INST_W-1:0] ifu_idu_inst;
  logic [PC_W-1:0]   ifu_idu_pc;
  logic              idu_ifu_inst_rdy;

  modport master (
    output imem_req_vld, imem_req_addr,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data,
    output ifu_idu_inst_vld, ifu_idu_inst, ifu_idu_pc,
    input  idu_ifu_inst_rdy
  );

  modport slave (
    input  imem_req_vld, imem_req_addr,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data,
    input  ifu_idu_inst_vld, ifu_idu_inst, ifu_idu_pc,
    output idu_ifu_inst_rdy
  );

endinterface

// File: rtl/ifu_ibuf_fifo.sv
// Synchronous instruction buffer FIFO.
//   clk, rst_clk : clock, asynchronous active-low reset
//   flush        : empties the buffer; overrides push and pop that cycle
//   push/push_data, pop : write / remove head (pop ignored when empty)
//   head         : combinational view of the oldest entry
//   count, full, empty : occupancy
module ifu_ibuf_fifo import ifu_pkg::*; #(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = ifu_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_clk,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_en_s, push_en_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full buffer is only accepted when a pop frees the slot.
  assign pop_en_s  = pop && !empty;
  assign push_en_s = push && (!full || pop_en_s);

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push_en_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(push_en_s) - (AW+1)'(pop_en_s);
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_fetch_ibuf.sv
// Instruction fetch and buffer stage.
//   clk, rst_clk  : clock, asynchronous active-low reset
//   pc            : current fetch pc from the PC generator
//   rob_ifu_flush : ROB redirect, squashes in-flight and buffered fetches
//   ifu_stall     : holds the PC generator; low only when pc is consumed
//   bus (master)  : imem request/response and decode instruction stream
// One memory request is outstanding at most; a credit check makes sure
// every issued request has a free buffer slot when its response returns.
module ifu_fetch_ibuf import ifu_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic [PC_W-1:0]   pc,
  input  logic              rob_ifu_flush,
  output logic              ifu_stall,
  ifu_fetch_ibuf_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  entry_t          push_data_s;
  entry_t          head_s;
  logic [CW-1:0]   count_s;
  logic            full_s, empty_s;
  logic            push_s, pop_s, hs_s;
  logic            req_vld_s, stall_s;
  logic [CW:0]     occ_s, occ_after_s;
  logic            credit_ok_s, credit_after_s;

  assign hs_s   = (state_q == REQ) && bus.imem_req_rdy;
  assign pop_s  = bus.idu_ifu_inst_rdy && !empty_s;
  assign push_s = (state_q == WAIT) && bus.imem_rsp_vld && !rob_ifu_flush
                  && (!full_s || pop_s);

  assign push_data_s.pc   = pc_q;
  assign push_data_s.inst = bus.imem_rsp_data;

  // An outstanding request already owns a slot, so it counts as occupied.
  assign occ_s          = {1'b0, count_s} + {{CW{1'b0}}, (state_q == WAIT)};
  assign credit_ok_s    = (occ_s < (CW+1)'(DEPTH));
  assign occ_after_s    = {1'b0, count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
  assign credit_after_s = (occ_after_s < (CW+1)'(DEPTH));

  // Next-state, request and stall generation; a flush overrides every event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_vld_s = 1'b0;
    stall_s   = 1'b1;
    case (state_q)
      IDLE: begin
        if (rob_ifu_flush) begin
          state_d = IDLE;
        end else if (credit_ok_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        req_vld_s = 1'b1;
        if (hs_s) begin
          stall_s = 1'b0;
          pc_d    = pc;
          // A request accepted during a redirect fetches a stale pc.
          state_d = rob_ifu_flush ? DROP : WAIT;
        end else begin
          state_d = rob_ifu_flush ? IDLE : REQ;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_vld) begin
          if (rob_ifu_flush) begin
            state_d = IDLE;
          end else begin
            state_d = credit_after_s ? REQ : IDLE;
          end
        end else begin
          state_d = rob_ifu_flush ? DROP : WAIT;
        end
      end
      DROP: begin
        state_d = bus.imem_rsp_vld ? IDLE : DROP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and the pc of the outstanding request.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      state_q <= IDLE;
      pc_q    <= {PC_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifu_ibuf_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_clk   (rst_clk),
    .flush     (rob_ifu_flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign ifu_stall            = stall_s;
  assign bus.imem_req_vld     = req_vld_s;
  assign bus.imem_req_addr    = pc;
  assign bus.ifu_idu_inst_vld = !empty_s;
  assign bus.ifu_idu_inst     = head_s.inst;
  assign bus.ifu_idu_pc       = head_s.pc;

endmodule

// File: tb/tb_ifu_fetch_ibuf.sv
// Directed bench for ifu_fetch_ibuf: a 1-cycle memory model answering each
// accepted request with inst = {addr[15:0], 16'h0013}, and a PC generator
// model that advances by 4 when stall is low and loads the redirect target
// on a flush.
module tb_ifu_fetch_ibuf;
  import ifu_pkg::*;

  logic        clk;
  logic        rst_clk;
  logic [63:0] pc;
  logic        rob_ifu_flush;
  logic        ifu_stall;
  logic [63:0] flush_pc;
  int          n_checks;
  int          n_pass;

  ifu_fetch_ibuf_if #(.PC_W(64), .INST_W(32)) bus ();

  ifu_fetch_ibuf #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clk           (clk),
    .rst_clk       (rst_clk),
    .pc            (pc),
    .rob_ifu_flush (rob_ifu_flush),
    .ifu_stall     (ifu_stall),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake/stall before the edge, then update the
  // PC generator and memory models after it.
  task automatic tick();
    logic        hs;
    logic        stall;
    logic        fl;
    logic [63:0] addr;
    hs    = bus.imem_req_vld && bus.imem_req_rdy;
    stall = ifu_stall;
    fl    = rob_ifu_flush;
    addr  = bus.imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    if (fl) pc = flush_pc;
    else if (!stall) pc = pc + 64'd4;
    rob_ifu_flush     = 1'b0;
    bus.imem_rsp_vld  = hs;
    bus.imem_rsp_data = hs ? mk_inst(addr) : 32'd0;
    #1;
  endtask

  function automatic logic [63:0] st();
    return {62'd0, dut.state_q};
  endfunction

  function automatic logic [63:0] cnt();
    return {61'd0, dut.u_fifo.count_q};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_clk  = 1'b1;
    pc       = PC_RESET;
    flush_pc = 64'd0;
    rob_ifu_flush        = 1'b0;
    bus.imem_req_rdy     = 1'b1;
    bus.imem_rsp_vld     = 1'b0;
    bus.imem_rsp_data    = 32'd0;
    bus.idu_ifu_inst_rdy = 1'b0;
    #2 rst_clk = 1'b0;
    @(negedge clk);
    #1;
    check_val("rst_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    check_val("rst_inst", {32'd0, bus.ifu_idu_inst}, 64'd0);
    check_val("rst_idu_pc", bus.ifu_idu_pc, 64'd0);
    check_val("rst_req_vld", {63'd0, bus.imem_req_vld}, 64'd0);
    check_val("rst_stall", {63'd0, ifu_stall}, 64'd1);

    // Release reset with a stray response in IDLE.
    @(negedge clk);
    rst_clk           = 1'b1;
    bus.imem_rsp_vld  = 1'b1;
    bus.imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    check_val("idle_req_vld", {63'd0, bus.imem_req_vld}, 64'd0);
    check_val("idle_stall", {63'd0, ifu_stall}, 64'd1);
    tick();
    check_val("stray_no_push", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    check_val("req1_vld", {63'd0, bus.imem_req_vld}, 64'd1);
    check_val("req1_addr", bus.imem_req_addr, 64'h8000_0000);
    check_val("req1_stall", {63'd0, ifu_stall}, 64'd0);
    tick();
    check_val("wait_req_vld", {63'd0, bus.imem_req_vld}, 64'd0);
    check_val("wait_stall", {63'd0, ifu_stall}, 64'd1);
    check_val("wait_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    tick();
    check_val("lat_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd1);
    check_val("lat_inst", {32'd0, bus.ifu_idu_inst}, 64'h13);
    check_val("lat_pc", bus.ifu_idu_pc, 64'h8000_0000);

    // Memory not ready for 3 cycles: request and address hold, stall high.
    for (int i = 0; i < 3; i++) begin
      bus.imem_req_rdy = 1'b0;
      #1;
      check_val("bp_req_vld", {63'd0, bus.imem_req_vld}, 64'd1);
      check_val("bp_addr", bus.imem_req_addr, 64'h8000_0004);
      check_val("bp_stall", {63'd0, ifu_stall}, 64'd1);
      tick();
    end
    bus.imem_req_rdy = 1'b1;
    #1;
    check_val("bp_rdy_stall", {63'd0, ifu_stall}, 64'd0);
    check_val("bp_rdy_addr", bus.imem_req_addr, 64'h8000_0004);

    // Decode blocked: fill to DEPTH, then fetch must stop.
    for (int i = 0; i < 6; i++) tick();
    check_val("full_count", cnt(), 64'd4);
    check_val("full_state", st(), {62'd0, IDLE});
    check_val("full_req_vld", {63'd0, bus.imem_req_vld}, 64'd0);
    tick();
    check_val("full_hold_req", {63'd0, bus.imem_req_vld}, 64'd0);
    bus.idu_ifu_inst_rdy = 1'b1;
    #1;
    check_val("full_head_pc", bus.ifu_idu_pc, 64'h8000_0000);
    check_val("full_head_inst", {32'd0, bus.ifu_idu_inst}, 64'h13);
    tick();
    bus.idu_ifu_inst_rdy = 1'b0;
    #1;
    check_val("pop_count", cnt(), 64'd3);
    check_val("pop_head_pc", bus.ifu_idu_pc, 64'h8000_0004);
    check_val("pop_head_inst", {32'd0, bus.ifu_idu_inst}, 64'h0004_0013);
    tick();
    check_val("resume_req_vld", {63'd0, bus.imem_req_vld}, 64'd1);
    check_val("resume_addr", bus.imem_req_addr, 64'h8000_0010);

    // Reset while a response is outstanding; it arrives after release.
    tick();
    check_val("pre_rst_state", st(), {62'd0, WAIT});
    rst_clk = 1'b0;
    #1;
    check_val("mrst_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    check_val("mrst_inst", {32'd0, bus.ifu_idu_inst}, 64'd0);
    check_val("mrst_stall", {63'd0, ifu_stall}, 64'd1);
    check_val("mrst_state", st(), {62'd0, IDLE});
    rst_clk = 1'b1;
    pc      = PC_RESET;
    #1;
    check_val("mrst_req_vld", {63'd0, bus.imem_req_vld}, 64'd0);
    tick();
    check_val("late_rsp_ignored", cnt(), 64'd0);
    check_val("late_rsp_req", bus.imem_req_addr, 64'h8000_0000);

    // Flush together with a handshake at 0x80000008.
    for (int i = 0; i < 4; i++) tick();
    check_val("pre_fl_addr", bus.imem_req_addr, 64'h8000_0008);
    check_val("pre_fl_count", cnt(), 64'd2);
    rob_ifu_flush = 1'b1;
    flush_pc      = 64'h8000_1000;
    #1;
    tick();
    check_val("fl_hs_state", st(), {62'd0, DROP});
    check_val("fl_hs_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    check_val("fl_hs_count", cnt(), 64'd0);
    check_val("drop_stall", {63'd0, ifu_stall}, 64'd1);
    tick();
    check_val("drop_state", st(), {62'd0, IDLE});
    check_val("drop_discard", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    tick();
    check_val("redir_req_vld", {63'd0, bus.imem_req_vld}, 64'd1);
    check_val("redir_addr", bus.imem_req_addr, 64'h8000_1000);

    // Flush in WAIT with response, 2 buffered entries and a pop.
    for (int i = 0; i < 5; i++) tick();
    check_val("wfl_state", st(), {62'd0, WAIT});
    check_val("wfl_count", cnt(), 64'd2);
    check_val("wfl_head_inst", {32'd0, bus.ifu_idu_inst}, 64'h1000_0013);
    rob_ifu_flush        = 1'b1;
    flush_pc             = 64'h8000_2000;
    bus.idu_ifu_inst_rdy = 1'b1;
    #1;
    tick();
    bus.idu_ifu_inst_rdy = 1'b0;
    #1;
    check_val("wfl_inst_vld", {63'd0, bus.ifu_idu_inst_vld}, 64'd0);
    check_val("wfl_idle", st(), {62'd0, IDLE});
    check_val("wfl_empty", cnt(), 64'd0);
    tick();
    check_val("wfl_redir_addr", bus.imem_req_addr, 64'h8000_2000);
    check_val("wfl_redir_vld", {63'd0, bus.imem_req_vld}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
